// File: rtl/i2c_master_if.sv
// Command/response and two-wire bus signals shared between the EEPROM
// register logic (slave view), the bus initiator (master view) and the wires.
interface i2c_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       scl;
  logic       sda_out;
  logic       sda_in;

  modport master (
    input  cmd_valid, cmd, wr_data, cmd_nack, sda_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, scl, sda_out
  );

  modport slave (
    output cmd_valid, cmd, wr_data, cmd_nack, sda_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, scl, sda_out
  );
endinterface

// File: rtl/i2c_master.sv
// Two-wire bus initiator: one START/WRITE/READ/STOP command at a time, each
// phase split into four quarters of CLK_DIV cycles with registered SCL/SDA.
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  i2c_master_if.master bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_STOP, ST_XFER, ST_DONE} state_t;

  localparam logic [7:0] LP_QLAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_qcnt;
  logic [1:0] r_quarter;
  logic [2:0] r_bit;
  logic       r_ack;
  logic       r_rd;
  logic [7:0] r_wdata;
  logic       r_nack;
  logic [7:0] r_shift;
  logic       r_ack_smp;
  logic       r_scl;
  logic       r_sda;
  logic       r_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_nack;

  state_t     w_cmd_st;
  logic       w_cmd_rd;
  logic       w_sample;

  // Bus levels {scl, sda} for a given quarter of a phase.
  function automatic logic [1:0] f_drive(input state_t st, input logic [1:0] q,
                                         input logic [2:0] b, input logic ack,
                                         input logic rd, input logic [7:0] wd,
                                         input logic nk);
    logic [1:0] v;
    v = 2'b11;
    case (st)
      ST_START: begin
        case (q)
          2'd0:    v = 2'b01;
          2'd1:    v = 2'b11;
          2'd2:    v = 2'b10;
          default: v = 2'b00;
        endcase
      end
      ST_STOP: begin
        case (q)
          2'd0:    v = 2'b00;
          2'd1:    v = 2'b10;
          default: v = 2'b11;
        endcase
      end
      ST_XFER: begin
        v[1] = (q == 2'd1) || (q == 2'd2);
        if (ack) v[0] = rd ? nk : 1'b1;
        else     v[0] = rd ? 1'b1 : wd[b];
      end
      default: v = 2'b11;
    endcase
    return v;
  endfunction

  always_comb begin
    w_cmd_st = ST_XFER;
    case (bus.cmd)
      2'd0:    w_cmd_st = ST_START;
      2'd3:    w_cmd_st = ST_STOP;
      default: w_cmd_st = ST_XFER;
    endcase
  end

  assign w_cmd_rd = (bus.cmd == 2'd2);
  assign w_sample = (r_state == ST_XFER) && (r_quarter == 2'd2) && (r_qcnt == LP_QLAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_qcnt      <= '0;
      r_quarter   <= '0;
      r_bit       <= '0;
      r_ack       <= 1'b0;
      r_rd        <= 1'b0;
      r_wdata     <= '0;
      r_nack      <= 1'b0;
      r_shift     <= '0;
      r_ack_smp   <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_nack  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid && r_ready) begin
            r_state   <= w_cmd_st;
            r_ready   <= 1'b0;
            r_rd      <= w_cmd_rd;
            r_wdata   <= bus.wr_data;
            r_nack    <= bus.cmd_nack;
            r_qcnt    <= LP_QLAST;
            r_quarter <= 2'd0;
            r_bit     <= 3'd7;
            r_ack     <= 1'b0;
            {r_scl, r_sda} <= f_drive(w_cmd_st, 2'd0, 3'd7, 1'b0, w_cmd_rd,
                                      bus.wr_data, bus.cmd_nack);
          end
        end
        ST_DONE: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= ST_IDLE;
          r_quarter   <= 2'd0;
          r_bit       <= 3'd0;
          r_ack       <= 1'b0;
        end
        default: begin
          if (w_sample) begin
            if (r_ack) r_ack_smp <= bus.sda_in;
            else       r_shift   <= {r_shift[6:0], bus.sda_in};
          end
          if (r_qcnt != 8'd0) begin
            r_qcnt <= r_qcnt - 8'd1;
          end else if (r_quarter != 2'd3) begin
            r_quarter <= r_quarter + 2'd1;
            r_qcnt    <= LP_QLAST;
            {r_scl, r_sda} <= f_drive(r_state, r_quarter + 2'd1, r_bit, r_ack,
                                      r_rd, r_wdata, r_nack);
          end else if (r_state == ST_XFER && !r_ack) begin
            // Bit 0 rolls into the ack slot; the bit index is then don't-care.
            r_quarter <= 2'd0;
            r_qcnt    <= LP_QLAST;
            if (r_bit == 3'd0) r_ack <= 1'b1;
            else               r_bit <= r_bit - 3'd1;
            {r_scl, r_sda} <= f_drive(ST_XFER, 2'd0, r_bit - 3'd1, (r_bit == 3'd0),
                                      r_rd, r_wdata, r_nack);
          end else begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            if (r_state == ST_XFER) begin
              r_rsp_data <= r_shift;
              r_rsp_nack <= r_rd ? r_nack : r_ack_smp;
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_nack  = r_rsp_nack;
  assign bus.scl       = r_scl;
  assign bus.sda_out   = r_sda;

endmodule

// File: doc/i2c_master.md
# i2c_master

Two-wire bus initiator that drives the serial EEPROM interface of the cartridge save port: SCL generation, START/STOP conditions, byte writes and byte reads with acknowledge handling. It sits between the CPU-side EEPROM register logic, which issues one command at a time, and the two bus wires toward the EEPROM responder. SDA is modelled open-drain: `sda_out`=0 pulls low, 1 releases. Bit sequencing matches the responder's START detection (SDA edge while SCL high) and its sampling on the SCL rising edge.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCL quarter-period; legal range 1..255.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd` in 2: 0 START, 1 WRITE, 2 READ, 3 STOP.
- `wr_data` in 8: byte for WRITE; sent MSB first.
- `cmd_nack` in 1: acknowledge bit the master drives after a READ byte (1 = NACK, the last byte).
- `rsp_valid` out 1: one-cycle pulse on command completion.
- `rsp_data` out 8: byte sampled from `sda_in` during WRITE/READ data bits.
- `rsp_nack` out 1: SDA sampled in the ack slot (WRITE), or `cmd_nack` echoed (READ).
- `scl` out 1: bus clock.
- `sda_out` out 1: SDA drive (0 = pull low).
- `sda_in` in 1: resolved SDA level.

## Operation
- Reset values: `scl`=1, `sda_out`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_nack`=0. The FSM is in IDLE and the quarter and bit counters are 0.
- FSM states: IDLE, START, STOP, XFER (WRITE or READ, selected by a latched direction flag), DONE.
- On accept, `cmd`, `wr_data` and `cmd_nack` are latched. The FSM leaves IDLE on the next clk edge, and `cmd_ready` drops at that edge.
- Each bus phase is 4 quarters (Q0..Q3) of `CLK_DIV` cycles, counted by an 8-bit down-counter.
- START: Q0 scl=0 sda=1; Q1 scl=1 sda=1; Q2 scl=1 sda=0; Q3 scl=0 sda=0. This is also valid as a repeated START mid-transfer.
- STOP: Q0 scl=0 sda=0; Q1 scl=1 sda=0; Q2 scl=1 sda=1; Q3 scl=1 sda=1. The bus ends idle.
- Data/ack bit: Q0 scl=0 with sda set to the bit value; Q1 and Q2 scl=1; Q3 scl=0. `sda_in` is sampled on the first clk cycle of Q2.
- XFER covers 9 bits: 8 data bits (counter 7..0) followed by the ack slot.
  - WRITE data bits: sda = `wr_data` bit.
  - READ data bits: sda = 1 (released).
  - WRITE ack slot: sda = 1; the sampled value goes to `rsp_nack`.
  - READ ack slot: sda = latched `cmd_nack`; `rsp_nack` = `cmd_nack`.
- Sampled data bits are shifted MSB first into `rsp_data`, which updates only at DONE. START and STOP leave `rsp_data` and `rsp_nack` unchanged.
- DONE lasts one cycle: `rsp_valid`=1, then the FSM returns to IDLE.
- No sequencing checks: WRITE/READ without a preceding START, or STOP on an idle bus, execute the waveform as specified.

## Timing
- START/STOP: accept at edge T; waveform occupies T+1 .. T+4·CLK_DIV; `rsp_valid` at cycle T+4·CLK_DIV+1; `cmd_ready`=1 again in the cycle after that.
- WRITE/READ: waveform length 36·CLK_DIV cycles; `rsp_valid` at T+36·CLK_DIV+1.
- Back-to-back: the next command can be accepted in the first IDLE cycle after DONE. `scl` and `sda_out` hold their last Q3 values while IDLE.
- `cmd_valid` while `cmd_ready`=0 is ignored, with no queueing.
- `scl` and `sda_out` are registered outputs with no combinational path from inputs.
- Reset asserted mid-phase: outputs go to reset values asynchronously and the bus is released (scl=1, sda=1); no STOP is generated.

## Test plan
- Reset/idle: hold `reset`=0 mid-WRITE -> `scl`=1, `sda_out`=1, `cmd_ready`=1, `rsp_valid`=0 within the same cycle; after release, no bus toggling without a command.
- START then STOP, CLK_DIV=2: SDA falls while SCL is high, 8 cycles per phase; STOP shows an SDA rise while SCL is high; `rsp_valid` at T+9 for each; bus ends scl=1, sda=1.
- WRITE 0xA0 with a responder model pulling `sda_in` low in the ack slot: SDA bits 1,0,1,0,0,0,0,0 on the SCL highs; `rsp_nack`=0; `rsp_data`=0xA0; `rsp_valid` at T+73 (CLK_DIV=2).
- WRITE 0x55 with `sda_in` floating high in the ack slot -> `rsp_nack`=1.
- READ with `cmd_nack`=1, model driving 0x3C: `sda_out`=1 for all data bits and in the ack slot; `rsp_data`=0x3C; `rsp_nack`=1. Repeat with `cmd_nack`=0: `sda_out`=0 in the ack slot.
- `cmd_valid` held high for 3 commands with CLK_DIV=1: each accepted only in the cycle after its predecessor's DONE; WRITE `rsp_valid` at T+37; no command is dropped or duplicated.
